// File: rtl/sigmoid_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-latency sigmoid pipe among NUM_REQ requesters.
// Optional issue counter enabled by defining SIGMOID_SCHED_STATS_EN.
module sigmoid_rr_scheduler #(
    parameter int BITSIZE  = 16,
    parameter int NUM_REQ  = 4,
    parameter int PIPE_LAT = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*BITSIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [BITSIZE-1:0]         pipe_in,
    input  logic [BITSIZE-1:0]         pipe_out,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [BITSIZE-1:0]         rsp_data,
    input  logic                       flush,
    output logic                       flush_done,
    output logic                       busy,
    output logic [31:0]                issue_count
);

    // state   | meaning
    // S_RUN   | arbitrate, one grant per cycle at most
    // S_DRAIN | no grants, wait for the in-flight results to retire
    // S_DONE  | flush_done pulse, back to S_RUN

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(PIPE_LAT + 1) + 1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic              arb_en;
    logic [IW-1:0]     ptr;
    logic              grant_any;
    logic [IW-1:0]     grant_idx;
    logic              tag_valid [PIPE_LAT];
    logic [IW-1:0]     tag_idx   [PIPE_LAT];
    logic              last_valid;
    logic [CW-1:0]     count, count_next;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_RUN;
        else       state <= state_next;
    end

    // Leaving DRAIN on the projected count lets flush_done land the cycle right
    // after the last response instead of one cycle later.
    always_comb begin
        state_next = state;
        case (state)
            S_RUN:   if (flush) state_next = S_DRAIN;
            S_DRAIN: if (count_next == '0) state_next = S_DONE;
            S_DONE:  state_next = S_RUN;
            default: state_next = S_RUN;
        endcase
    end

    always_comb begin
        arb_en     = (state == S_RUN) && !flush;
        flush_done = (state == S_DONE);
    end

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (arb_en) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!grant_any && req_valid[wrap_add(ptr, j)]) begin
                    grant_any = 1'b1;
                    grant_idx = wrap_add(ptr, j);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) req_ready[grant_idx] = 1'b1;
        pipe_in = grant_any ? req_data[int'(grant_idx)*BITSIZE +: BITSIZE] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_valid[i] <= 1'b0;
                tag_idx[i]   <= '0;
            end
        end else begin
            tag_valid[0] <= grant_any;
            tag_idx[0]   <= grant_idx;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_idx[i]   <= tag_idx[i-1];
            end
        end
    end

    assign last_valid = tag_valid[PIPE_LAT-1];

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = last_valid && (tag_idx[PIPE_LAT-1] == IW'(i));
        end
    end

    assign rsp_data = pipe_out;

    always_comb begin
        count_next = count;
        if (grant_any && !last_valid)      count_next = count + CW'(1);
        else if (!grant_any && last_valid) count_next = count - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count <= '0;
        else       count <= count_next;
    end

    assign busy = (count != '0);

`ifdef SIGMOID_SCHED_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          issue_count <= '0;
        else if (grant_any) issue_count <= issue_count + 32'd1;
    end
`else
    assign issue_count = '0;
`endif

endmodule

// File: tb/tb_sigmoid_rr_scheduler.sv
// Directed bench for sigmoid_rr_scheduler with a behavioural 3-stage sigmoid pipe
// and a response scoreboard.
module tb_sigmoid_rr_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [15:0] pipe_in;
    logic [15:0] pipe_out;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        flush;
    logic        flush_done;
    logic        busy;
    logic [31:0] issue_count;

    logic [15:0] opnd [4];
    logic [15:0] p0, p1, p2;

    typedef struct {
        int         cyc;
        logic [3:0] oh;
        logic [15:0] data;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_issue  = 0;
    bit started  = 1'b0;

`ifdef SIGMOID_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    sigmoid_rr_scheduler #(.BITSIZE(16), .NUM_REQ(4), .PIPE_LAT(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .pipe_in     (pipe_in),
        .pipe_out    (pipe_out),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .flush       (flush),
        .flush_done  (flush_done),
        .busy        (busy),
        .issue_count (issue_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign req_data = {opnd[3], opnd[2], opnd[1], opnd[0]};

    // Piecewise-linear sigmoid: 0.5 - 1 lsb at zero, slope 1/4, saturating to [0, 0x7FF].
    function automatic logic [15:0] sig_f(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        v = (v >>> 2) + 'h3FF;
        if (v < 0)     v = 0;
        if (v > 'h7FF) v = 'h7FF;
        return 16'(v);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0 <= '0;
            p1 <= '0;
            p2 <= '0;
        end else begin
            p0 <= pipe_in;
            p1 <= p0;
            p2 <= p1;
        end
    end
    assign pipe_out = sig_f(p2);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard consumer and busy tracking: a result is in flight from the cycle
    // after its grant up to and including the cycle its response is visible.
    always @(negedge clk) begin
        if (started && !reset) begin
            logic exp_b;
            exp_t e;
            exp_b = 1'b0;
            foreach (q[i]) if (q[i].cyc - 2 <= cyc) exp_b = 1'b1;
            check("busy", {31'd0, busy}, {31'd0, exp_b});
            if (rsp_valid !== 4'b0000 || (q.size() > 0 && q[0].cyc == cyc)) begin
                if (q.size() == 0) begin
                    check("stale_rsp", {28'd0, rsp_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("rsp_valid", {28'd0, rsp_valid}, {28'd0, e.oh});
                    check("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
                    check("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic step(input logic [3:0] v, input logic fl, input logic [3:0] exp_rdy,
                        input logic exp_fd);
        int k;
        req_valid = v;
        flush     = fl;
        @(negedge clk);
        check("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
        check("flush_done", {31'd0, flush_done}, {31'd0, exp_fd});
        if (exp_rdy != 4'b0000) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (exp_rdy[i]) k = i;
            check("pipe_in", {16'd0, pipe_in}, {16'd0, opnd[k]});
            q.push_back('{cyc + 3, exp_rdy, sig_f(opnd[k])});
            n_issue++;
        end else begin
            check("pipe_in_idle", {16'd0, pipe_in}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 4'b0000, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        flush     = 1'b0;
        for (int i = 0; i < 4; i++) opnd[i] = '0;
        #1;
        check("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flush_done", {31'd0, flush_done}, 32'd0);
        check("rst_issue_count", issue_count, 32'd0);
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        started = 1'b1;

        // single operand: 0 -> 0x03FF, response after edge k+2
        step(4'b0001, 1'b0, 4'b0001, 1'b0);
        idle(2);
        @(negedge clk);
        check("single_rsp_valid", {28'd0, rsp_valid}, 32'h1);
        check("single_rsp_data", {16'd0, rsp_data}, 32'h03FF);
        @(posedge clk);
        #1;
        idle(2);

        // move ptr to 0, then all four held valid for 8 cycles
        opnd[0] = 16'h0100; opnd[1] = 16'hFF00; opnd[2] = 16'h1000; opnd[3] = 16'hF000;
        step(4'b1000, 1'b0, 4'b1000, 1'b0);
        for (int r = 0; r < 2; r++) begin
            step(4'b1111, 1'b0, 4'b0001, 1'b0);
            step(4'b1111, 1'b0, 4'b0010, 1'b0);
            step(4'b1111, 1'b0, 4'b0100, 1'b0);
            step(4'b1111, 1'b0, 4'b1000, 1'b0);
        end
        idle(4);

        // sparse: ptr = 1 with only req 2 and req 0 valid
        opnd[0] = 16'h0040; opnd[2] = 16'hFFC0;
        step(4'b0001, 1'b0, 4'b0001, 1'b0);
        step(4'b0101, 1'b0, 4'b0100, 1'b0);
        step(4'b0101, 1'b0, 4'b0001, 1'b0);
        idle(4);

        // flush with three in flight
        opnd[1] = 16'h0004; opnd[2] = 16'h0008; opnd[3] = 16'hFFF0;
        step(4'b1111, 1'b0, 4'b0010, 1'b0);
        step(4'b1111, 1'b0, 4'b0100, 1'b0);
        step(4'b1111, 1'b0, 4'b1000, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 1'b0);
        step(4'b1111, 1'b0, 4'b0000, 1'b1);
        step(4'b1111, 1'b0, 4'b0001, 1'b0);
        idle(4);

        // flush while empty: pulse two cycles after flush
        step(4'b0000, 1'b1, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b1);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);

        // reset with two operands in flight
        step(4'b1111, 1'b0, 4'b0010, 1'b0);
        step(4'b1111, 1'b0, 4'b0100, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        check("pre_reset_rsp", {28'd0, rsp_valid}, 32'h2);
        req_valid = 4'b0000;
        reset     = 1'b1;
        #1;
        check("reset_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_issue_count", issue_count, 32'd0);
        q.delete();
        n_issue = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // ten grants after reset, starting at req 0
        step(4'b1111, 1'b0, 4'b0001, 1'b0);
        for (int r = 0; r < 2; r++) begin
            step(4'b1111, 1'b0, 4'b0010, 1'b0);
            step(4'b1111, 1'b0, 4'b0100, 1'b0);
            step(4'b1111, 1'b0, 4'b1000, 1'b0);
            step(4'b1111, 1'b0, 4'b0001, 1'b0);
        end
        step(4'b1111, 1'b0, 4'b0010, 1'b0);
        idle(5);
        check("issue_count", issue_count, STATS ? 32'(n_issue) : 32'd0);
        check("scoreboard_empty", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sigmoid_rr_scheduler.md
Name: sigmoid_rr_scheduler

Overview:
- Shares one pipelined sigmoid datapath (fixed-point, BITSIZE-wide, fixed latency, no stall) among NUM_REQ requesters, e.g. the neurons of one layer.
- Each cycle: round-robin grant of at most one request, mux of its operand into the pipe, and a tag carried alongside the pipe so each result returns to its originator.
- A drain/flush sequencer lets the layer controller wait until no results are in flight before switching layers.

Parameters:
- BITSIZE, 16, operand/result width (signed fixed point, same format as the sigmoid pipe).
- NUM_REQ, 4, number of requesters (2..16).
- PIPE_LAT, 3, rising edges from the pipe sampling data_in to the matching data_out being valid.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_data  in  NUM_REQ*BITSIZE  operands; requester i at bits [i*BITSIZE +: BITSIZE].
- req_ready  out  NUM_REQ  one-hot grant; a transfer happens when req_valid[i] and req_ready[i] are both high.
- pipe_in  out  BITSIZE  to sigmoid pipe data_in.
- pipe_out  in  BITSIZE  from sigmoid pipe data_out.
- rsp_valid  out  NUM_REQ  one-hot result strobe, 1 cycle.
- rsp_data  out  BITSIZE  result, valid when any rsp_valid bit is set.
- flush  in  1  drain request (level).
- flush_done  out  1  1-cycle pulse when the drain completes.
- busy  out  1  high while any result is in flight.
- issue_count  out  32  issued-operand counter (see Optional Feature).

Behaviour:
- Reset (async, immediate):
  - rr pointer = 0; tag pipe cleared; in-flight count = 0; state = RUN.
  - rsp_valid = 0, flush_done = 0, busy = 0, issue_count = 0.
  - In-flight results are dropped. The attached pipe shares the same reset.
- Arbitration (combinational, RUN state only):
  - Grant the first i with req_valid[i] = 1, searching from index ptr upward with wrap to 0.
  - req_ready = one-hot of the granted i; all zero if there is no valid request or state is not RUN.
  - req_ready never asserts without req_valid.
- pipe_in = req_data of the granted requester; 0 when there is no grant.
- On a grant edge: ptr <= (granted i + 1) mod NUM_REQ. ptr is unchanged when there is no grant.
- Tag pipe: PIPE_LAT stages of {valid, index}.
  - Stage 0 loads {grant, granted i} every edge; the stages shift every edge.
  - No backpressure exists, so throughput is one issue per cycle.
- Response: rsp_valid[idx] = stage[PIPE_LAT-1].valid decoded one-hot from its index (registered), and rsp_data = pipe_out (pass-through).
  - An operand accepted at edge k produces rsp_valid at the output of edge k+PIPE_LAT-1.
- In-flight count:
  - +1 on grant, −1 when the last tag stage is valid, with net 0 if both occur on the same edge.
  - busy = (count != 0).
- States:
  - RUN: arbitrate. When flush = 1, go to DRAIN; no grant occurs in the transition cycle.
  - DRAIN: no grants. When count == 0, go to DONE.
  - DONE: flush_done = 1 for exactly one cycle, then go to RUN.
- Flush boundaries:
  - If flush is still high on return to RUN, it is treated as a new request.
  - Flush while already empty: RUN → DRAIN → DONE, giving a pulse 2 cycles after flush.
- Fairness: a requester holding req_valid continuously is granted within NUM_REQ cycles.

Optional Feature:
- Macro: SIGMOID_SCHED_STATS_EN.
- Defined: issue_count is a 32-bit register, +1 on every grant, wraps 0xFFFFFFFF → 0, cleared by reset.
- Undefined: issue_count is tied to 0 and no counter logic is synthesized.

Test Plan:
- Single operand, real sigmoid pipe attached:
  - Stimulus: req 0 presents 16'h0000 at edge k.
  - Response: rsp_valid = 4'b0001 after edge k+2, rsp_data = 16'h03FF, busy low on the next cycle.
- All 4 requesters held valid for 8 cycles:
  - Required grant order: 0,1,2,3,0,1,2,3, one per cycle.
  - Required results: each rsp_valid[i] exactly twice, in issue order, 3 edges after the matching grant.
- Sparse requests:
  - Stimulus: only req 2 and req 0 valid, ptr = 1.
  - Required: grant 2 first, then 0; req_ready stays low for invalid requesters.
- Flush with 3 in flight:
  - Stimulus: assert flush.
  - Required: no further req_ready; flush_done pulses one cycle after the last rsp_valid; then arbitration resumes.
- Reset mid-operation:
  - Stimulus: assert reset with 2 operands in flight.
  - Required: rsp_valid = 0 immediately and no stale responses after release; ptr = 0, so req 0 wins next.
- Stats feature:
  - With SIGMOID_SCHED_STATS_EN: issue_count = 10 after 10 grants.
  - Without the macro: issue_count stays 0.
